div_nonrestoring_32: RTL

//  Sequential signed 32-bit integer divider for the multdiv unit; counterpart to the adder/multiplier datapath.

---
 rtl/div_nonrestoring_32_pkg.sv | 24 ++
 rtl/div_addsub_33.sv | 17 +
 rtl/div_nonrestoring_32.sv | 101 ++++++++++
 3 files changed

// File: rtl/div_nonrestoring_32_pkg.sv
// Shared widths, iteration count, FSM encoding and two's-complement helpers for the divider.
// Negation is ~x + 1, the same form the adder datapath uses for subtraction.
package div_nonrestoring_32_pkg;

  localparam int MD_WIDTH     = 32;
  localparam int MD_DIV_ITERS = 32;
  localparam int MD_CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [MD_WIDTH-1:0] neg32(input logic [MD_WIDTH-1:0] x);
    return ~x + MD_WIDTH'(1);
  endfunction

  // 0x80000000 maps to itself, which is the right magnitude when read as unsigned.
  function automatic logic [MD_WIDTH-1:0] abs32(input logic [MD_WIDTH-1:0] x);
    return x[MD_WIDTH-1] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/div_addsub_33.sv
// Combinational add/subtract for one non-restoring step: y = a + b, or a - b when sub=1.
// Zero latency; no flow control.
module div_addsub_33 #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y
);

  logic [W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign y     = a + b_eff + W'(sub);

endmodule

// File: rtl/div_nonrestoring_32.sv
// Sequential signed divider, non-restoring, one quotient bit per clock, truncates toward zero.
// Start-to-RDY latency is fixed at 33 clocks; a new start aborts any op in flight with no RDY for it.
module div_nonrestoring_32
  import div_nonrestoring_32_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MD_DIV_ITERS - 1);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   m_reg;
  logic             s_a;
  logic             s_b;
  logic             zero;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_final;

  // Add or subtract is chosen by the sign of the partial remainder before the shift.
  assign a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  div_addsub_33 #(.W(WIDTH + 1)) u_addsub (
    .a   (a_shift),
    .b   (m_reg),
    .sub (~a_reg[WIDTH]),
    .y   (a_next)
  );

  assign q_next  = {q_reg[WIDTH-2:0], ~a_next[WIDTH]};
  assign q_final = (s_a ^ s_b) ? neg32(q_reg) : q_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      a_reg          <= '0;
      q_reg          <= '0;
      m_reg          <= '0;
      s_a            <= 1'b0;
      s_b            <= 1'b0;
      zero           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;

      case (state)
        RUN: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            state <= DONE;
          end
        end
        DONE: begin
          data_result    <= zero ? '0 : q_final;
          data_exception <= zero;
          data_resultRDY <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // A start landing on the DONE edge still lets the finished op report.
      if (ctrl_DIV) begin
        s_a   <= data_operandA[WIDTH-1];
        s_b   <= data_operandB[WIDTH-1];
        zero  <= (data_operandB == '0);
        m_reg <= {1'b0, abs32(data_operandB)};
        q_reg <= abs32(data_operandA);
        a_reg <= '0;
        cnt   <= '0;
        state <= RUN;
        if (state != DONE) begin
          data_exception <= 1'b0;
        end
      end
    end
  end

endmodule
